mat_vec_loader: RTL

- Avalon-MM read master that feeds the matrix-vector MAC array.
- Fetches DEPTH matrix rows, then one vector line, from word-addressed memory behind mem_wrapper.
- Pushes each matrix row into the MAC A-FIFOs in parallel, then streams the vector into the B input one element per cycle.
- Replaces the ad-hoc fill logic in the top level with a reusable, restartable loader that honours MAC backpressure.

---
 rtl/mat_vec_loader.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mat_vec_loader.sv
// Avalon-MM read master that loads DEPTH matrix rows into the MAC A-FIFOs,
// then one vector line whose elements are streamed into the MAC B input.
// One read is outstanding at a time. Every push waits for mac_ready.
module mat_vec_loader #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 8,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [ADDR_WIDTH-1:0]       avm_address,
  output logic                        avm_read,
  input  logic [DEPTH*DATA_WIDTH-1:0] avm_readdata,
  input  logic                        avm_readdatavalid,
  input  logic                        avm_waitrequest,
  input  logic                        mac_ready,
  output logic                        mac_clr,
  output logic                        a_wren,
  output logic [DEPTH*DATA_WIDTH-1:0] a_row,
  output logic                        b_wren,
  output logic [DATA_WIDTH-1:0]       b_data
);

  localparam int LW = DEPTH * DATA_WIDTH;
  // Wide enough to hold the row offset DEPTH used for the vector line.
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_REQ_A,
    S_WAIT_A,
    S_PUSH_A,
    S_REQ_B,
    S_WAIT_B,
    S_PUSH_B,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [LW-1:0] a_row_q, a_row_d;
  logic [LW-1:0] vec_q, vec_d;
  logic          done_q, done_d;

  logic [CW-1:0]         addr_off;
  logic [DATA_WIDTH-1:0] vec_elem;
  logic                  last_row;
  logic                  last_elem;

  assign last_row  = (row_q == CW'(DEPTH - 1));
  assign last_elem = (idx_q == CW'(DEPTH - 1));

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      idx_q   <= '0;
      a_row_q <= '0;
      vec_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      a_row_q <= a_row_d;
      vec_q   <= vec_d;
      done_q  <= done_d;
    end
  end

  // Select vector element idx_q; element 0 occupies the most significant slot.
  always_comb begin
    vec_elem = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (idx_q == CW'(i)) begin
        vec_elem = vec_q[(DEPTH-1-i)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state logic: sequencing of requests, responses and MAC pushes.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    idx_d   = idx_q;
    a_row_d = a_row_q;
    vec_d   = vec_q;
    done_d  = done_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_CLEAR;
          done_d  = 1'b0;
        end
      end

      S_CLEAR: begin
        row_d   = '0;
        state_d = S_REQ_A;
      end

      S_REQ_A: begin
        if (!avm_waitrequest) begin
          state_d = S_WAIT_A;
        end
      end

      S_WAIT_A: begin
        if (avm_readdatavalid) begin
          a_row_d = avm_readdata;
          state_d = S_PUSH_A;
        end
      end

      S_PUSH_A: begin
        if (mac_ready) begin
          if (last_row) begin
            state_d = S_REQ_B;
          end else begin
            row_d   = row_q + CW'(1);
            state_d = S_REQ_A;
          end
        end
      end

      S_REQ_B: begin
        if (!avm_waitrequest) begin
          state_d = S_WAIT_B;
        end
      end

      S_WAIT_B: begin
        if (avm_readdatavalid) begin
          vec_d   = avm_readdata;
          idx_d   = '0;
          state_d = S_PUSH_B;
        end
      end

      S_PUSH_B: begin
        if (mac_ready) begin
          if (last_elem) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the current state and held registers.
  always_comb begin
    busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    done     = done_q;
    avm_read = (state_q == S_REQ_A) || (state_q == S_REQ_B);
    mac_clr  = (state_q == S_CLEAR);
    a_wren   = (state_q == S_PUSH_A);
    b_wren   = (state_q == S_PUSH_B);
    a_row    = a_row_q;
    b_data   = (state_q == S_PUSH_B) ? vec_elem : '0;
    addr_off = ((state_q == S_REQ_B) || (state_q == S_WAIT_B)) ? CW'(DEPTH) : row_q;
    avm_address = BASE_ADDR + ADDR_WIDTH'(addr_off);
  end

endmodule
